// File: rtl/aes_key_pkg.sv
// Shared types and constants for the AES-128 key-expansion pipeline.
//   key_t        128-bit key, byte i = bits [i*8 +: 8], word w = bytes 4w..4w+3
//   byte_t       one key byte
//   round_t      4-bit round index, 1..NUM_ROUNDS
//   state_t      final-stage acceptance state {FILL, LAST}
//   complete_word3()  word3 ^= word2, bytewise, no carries
package aes_key_pkg;

  typedef logic [127:0] key_t;
  typedef logic [7:0]   byte_t;
  typedef logic [3:0]   round_t;

  localparam int     NUM_ROUNDS = 10;
  localparam round_t LAST_ROUND = round_t'(NUM_ROUNDS);
  localparam round_t PENULT_RND = round_t'(NUM_ROUNDS - 1);

  typedef enum logic {
    FILL = 1'b0,
    LAST = 1'b1
  } state_t;

  // Bytes 0..11 pass through; byte 12+j picks up byte 8+j.
  function automatic key_t complete_word3(key_t k);
    key_t  r;
    byte_t b;
    r = k;
    for (int j = 0; j < 4; j++) begin
      b = k[(12 + j) * 8 +: 8] ^ k[(8 + j) * 8 +: 8];
      r[(12 + j) * 8 +: 8] = b;
    end
    return r;
  endfunction

endpackage

// File: rtl/expand_key3_128_if.sv
// Bus bundle for the final key-expansion stage.
//   in_key / in_key_rd / in_key_empty     read side of the word-2 stage FIFO
//   out_key / out_key_wr / out_key_full   write side of the round-key store FIFO
//   fb_key / fb_key_wr / fb_key_full      write side of the stage-1 feedback FIFO
//   out_round                             round tag (EXPAND_KEY_ROUND_TAG_EN only)
// Modports: slave = the expansion stage, master = the surrounding FIFOs.
interface expand_key3_128_if;
  import aes_key_pkg::*;

  key_t   in_key;
  logic   in_key_rd;
  logic   in_key_empty;
  key_t   out_key;
  logic   out_key_wr;
  logic   out_key_full;
  key_t   fb_key;
  logic   fb_key_wr;
  logic   fb_key_full;
`ifdef EXPAND_KEY_ROUND_TAG_EN
  round_t out_round;

  modport slave (
    input  in_key, in_key_empty, out_key_full, fb_key_full,
    output in_key_rd, out_key, out_key_wr, fb_key, fb_key_wr, out_round
  );
  modport master (
    output in_key, in_key_empty, out_key_full, fb_key_full,
    input  in_key_rd, out_key, out_key_wr, fb_key, fb_key_wr, out_round
  );
`else
  modport slave (
    input  in_key, in_key_empty, out_key_full, fb_key_full,
    output in_key_rd, out_key, out_key_wr, fb_key, fb_key_wr
  );
  modport master (
    output in_key, in_key_empty, out_key_full, fb_key_full,
    input  in_key_rd, out_key, out_key_wr, fb_key, fb_key_wr
  );
`endif
endinterface

// File: rtl/key_out_slot.sv
// Single-entry output buffer in front of a downstream FIFO.
//   load      capture data_in this cycle (caller only loads when free)
//   data_in   value to capture
//   full      downstream FIFO full
//   valid     slot holds an unwritten entry
//   wr        push strobe: valid && !full
//   data_out  held contents (keeps last value while invalid)
//   free      slot can accept a load this cycle (empty, or draining now)
module key_out_slot #(
  parameter int           W       = 128,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] data_in,
  input  logic         full,
  output logic         valid,
  output logic         wr,
  output logic [W-1:0] data_out,
  output logic         free
);

  assign wr   = valid && !full;
  assign free = !valid || !full;

  // NOTE: the data register is reset too, because the bus it drives has a
  // defined value out of reset; a plain datapath buffer would not need it.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid    <= 1'b0;
      data_out <= RST_VAL;
    end else if (load) begin
      // Covers drain-and-reload in one cycle: valid stays high, no bubble.
      valid    <= 1'b1;
      data_out <= data_in;
    end else if (wr) begin
      valid    <= 1'b0;
    end
  end

endmodule

// File: rtl/expand_key3_128.sv
// Final AES-128 key-expansion stage: completes word 3 (word3 ^= word2),
// counts rounds 1..NUM_ROUNDS and buffers each round key in two slots.
// Every key goes to the store FIFO; rounds 1..NUM_ROUNDS-1 also go to the
// feedback FIFO for the next round's expansion.
//   clk, rst_n  single clock, asynchronous active-low reset
//   bus         expand_key3_128_if.slave (see interface header)
// Optional: define EXPAND_KEY_ROUND_TAG_EN to store the accept-time round in
// the store slot and drive it on bus.out_round.
module expand_key3_128
  import aes_key_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  expand_key3_128_if.slave   bus
);

`ifdef EXPAND_KEY_ROUND_TAG_EN
  localparam int             STORE_W   = 132;
  localparam logic [131:0]   STORE_RST = {4'd1, 128'd0};
`else
  localparam int             STORE_W   = 128;
  localparam logic [127:0]   STORE_RST = '0;
`endif

  state_t               state, state_nxt;
  round_t               round, round_nxt;
  logic                 accept;
  logic                 load_fb;
  key_t                 key3;
  logic [STORE_W-1:0]   store_in;
  logic [STORE_W-1:0]   store_out;
  logic                 store_valid, store_free;
  logic                 fb_valid, fb_free;

  assign key3 = complete_word3(bus.in_key);

`ifdef EXPAND_KEY_ROUND_TAG_EN
  assign store_in      = {round, key3};
  assign bus.out_round = store_out[131:128];
`else
  assign store_in      = key3;
`endif
  assign bus.out_key   = store_out[127:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FILL;
      round <= 4'd1;
    end else begin
      state <= state_nxt;
      round <= round_nxt;
    end
  end

  // FILL needs both slots free; LAST only feeds the store FIFO, so a stalled
  // feedback FIFO cannot hold up the final round key.
  // NOTE: every output of this block gets a default first, so no path
  // through the case leaves a signal unassigned and no latch is inferred.
  always_comb begin
    accept    = 1'b0;
    state_nxt = state;
    round_nxt = round;
    case (state)
      FILL: begin
        if (!bus.in_key_empty && store_free && fb_free) begin
          accept    = 1'b1;
          round_nxt = round + 4'd1;
          if (round == PENULT_RND) state_nxt = LAST;
        end
      end
      LAST: begin
        if (!bus.in_key_empty && store_free) begin
          accept    = 1'b1;
          round_nxt = 4'd1;
          state_nxt = FILL;
        end
      end
      default: state_nxt = FILL;
    endcase
  end

  assign load_fb       = accept && (state == FILL);
  assign bus.in_key_rd = accept;

  key_out_slot #(.W(STORE_W), .RST_VAL(STORE_RST)) u_store (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .data_in  (store_in),
    .full     (bus.out_key_full),
    .valid    (store_valid),
    .wr       (bus.out_key_wr),
    .data_out (store_out),
    .free     (store_free)
  );

  key_out_slot #(.W(128), .RST_VAL(128'd0)) u_fb (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load_fb),
    .data_in  (key3),
    .full     (bus.fb_key_full),
    .valid    (fb_valid),
    .wr       (bus.fb_key_wr),
    .data_out (bus.fb_key),
    .free     (fb_free)
  );

endmodule

// File: tb/tb_expand_key3_128.sv
module tb_expand_key3_128;
  import aes_key_pkg::*;

  typedef struct {
    key_t   key;
    round_t rnd;
  } exp_t;

  logic clk;
  logic rst_n;
  expand_key3_128_if bus ();

  expand_key3_128 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int     tests = 0;
  int     fails = 0;
  int     store_writes = 0;
  int     fb_writes = 0;
  key_t   src_q[$];
  exp_t   store_q[$];
  key_t   fb_q[$];
  round_t model_round = 4'd1;
  bit     toggle_full = 1'b0;

  // Independent reference: upper word XOR third word.
  function automatic key_t ref_key(key_t k);
    key_t r;
    r = k;
    r[127:96] = k[127:96] ^ k[95:64];
    return r;
  endfunction

  function automatic key_t rand_key();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Scoreboard: accepts push expectations, write strobes pop and compare.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.in_key_rd) begin
        tests++;
        assert (bus.in_key_empty === 1'b0 && src_q.size() != 0) else begin
          fails++; $error("FAIL rd_when_empty: rd=1 empty=%b", bus.in_key_empty);
        end
        if (src_q.size() != 0) begin
          key_t k;
          exp_t e;
          k = src_q.pop_front();
          e.key = ref_key(k);
          e.rnd = model_round;
          store_q.push_back(e);
          if (model_round != 4'd10) fb_q.push_back(e.key);
          model_round = (model_round == 4'd10) ? 4'd1 : model_round + 4'd1;
        end
      end
      if (bus.out_key_wr) begin
        store_writes++;
        tests++;
        assert (store_q.size() != 0) else begin
          fails++; $error("FAIL store_extra: unexpected out_key_wr key=%h", bus.out_key);
        end
        if (store_q.size() != 0) begin
          exp_t e;
          e = store_q.pop_front();
          tests++;
          assert (bus.out_key === e.key) else begin
            fails++; $error("FAIL store_key: got %h expected %h", bus.out_key, e.key);
          end
`ifdef EXPAND_KEY_ROUND_TAG_EN
          tests++;
          assert (bus.out_round === e.rnd) else begin
            fails++; $error("FAIL store_round: got %0d expected %0d", bus.out_round, e.rnd);
          end
`endif
        end
      end
      if (bus.fb_key_wr) begin
        fb_writes++;
        tests++;
        assert (fb_q.size() != 0) else begin
          fails++; $error("FAIL fb_extra: unexpected fb_key_wr key=%h", bus.fb_key);
        end
        if (fb_q.size() != 0) begin
          key_t f;
          f = fb_q.pop_front();
          tests++;
          assert (bus.fb_key === f) else begin
            fails++; $error("FAIL fb_key: got %h expected %h", bus.fb_key, f);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (toggle_full) bus.out_key_full = ~bus.out_key_full;
    bus.in_key       = (src_q.size() != 0) ? src_q[0] : '0;
    bus.in_key_empty = (src_q.size() == 0);
  endtask

  task automatic chk(string tag, logic [127:0] got, logic [127:0] want);
    tests++;
    assert (got === want) else begin
      fails++; $error("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  task automatic drain(int max_cycles);
    int n = 0;
    while ((src_q.size() != 0 || store_q.size() != 0 || fb_q.size() != 0) && n < max_cycles) begin
      tick();
      n++;
    end
    tests++;
    assert (src_q.size() == 0 && store_q.size() == 0 && fb_q.size() == 0) else begin
      fails++; $error("FAIL drain_timeout: src=%0d store=%0d fb=%0d left after %0d cycles",
                      src_q.size(), store_q.size(), fb_q.size(), n);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    bus.in_key_empty = 1'b1;
    bus.out_key_full = 1'b0;
    bus.fb_key_full  = 1'b0;
    rst_n = 1'b0;
    src_q.delete();
    store_q.delete();
    fb_q.delete();
    model_round = 4'd1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    key_t fk;
    int   sw0, fw0;

    // Reset values.
    rst_n = 1'b0;
    bus.in_key = '0;
    bus.in_key_empty = 1'b1;
    bus.out_key_full = 1'b0;
    bus.fb_key_full = 1'b0;
    #1;
    chk("rst_rd",      128'(bus.in_key_rd), 128'd0);
    chk("rst_out_wr",  128'(bus.out_key_wr), 128'd0);
    chk("rst_fb_wr",   128'(bus.fb_key_wr), 128'd0);
    chk("rst_out_key", bus.out_key, 128'd0);
    chk("rst_fb_key",  bus.fb_key, 128'd0);
`ifdef EXPAND_KEY_ROUND_TAG_EN
    chk("rst_round",   128'(bus.out_round), 128'd1);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // FIPS-197 round-1 fragment.
    fk = '0;
    fk[63:0]   = 64'h0123456789abcdef;
    fk[95:64]  = {8'h39, 8'h39, 8'ha3, 8'h23};
    fk[127:96] = {8'h3c, 8'h4f, 8'hcf, 8'h09};
    src_q.push_back(fk);
    tick();
    @(negedge clk); #1;
    chk("fips_rd", 128'(bus.in_key_rd), 128'd1);
    tick();
    @(negedge clk); #1;
    chk("fips_out_wr", 128'(bus.out_key_wr), 128'd1);
    chk("fips_fb_wr",  128'(bus.fb_key_wr), 128'd1);
    chk("fips_word3",  128'(bus.out_key[127:96]), 128'(32'h05766c2a));
`ifdef EXPAND_KEY_ROUND_TAG_EN
    chk("fips_round",  128'(bus.out_round), 128'd1);
`endif
    repeat (2) tick();
    @(negedge clk); #1;
    chk("fips_hold", 128'(bus.out_key[127:96]), 128'(32'h05766c2a));

    // Eleven back-to-back keys: rounds 1..10 then 1.
    do_reset();
    sw0 = store_writes; fw0 = fb_writes;
    for (int i = 0; i < 11; i++) src_q.push_back(rand_key());
    for (int i = 0; i < 11; i++) begin
      tick();
      @(negedge clk); #1;
      chk("b2b_rd", 128'(bus.in_key_rd), 128'd1);
    end
    drain(20);
    chk("b2b_store_cnt", 128'(store_writes - sw0), 128'd11);
    chk("b2b_fb_cnt",    128'(fb_writes - fw0), 128'd10);

    // Feedback stall in FILL.
    do_reset();
    src_q.push_back(rand_key());
    src_q.push_back(rand_key());
    tick();
    @(negedge clk); #1;
    chk("stall_rd0", 128'(bus.in_key_rd), 128'd1);
    tick();
    bus.fb_key_full = 1'b1;
    @(negedge clk); #1;
    chk("stall_rd1",     128'(bus.in_key_rd), 128'd0);
    chk("stall_out_wr",  128'(bus.out_key_wr), 128'd1);
    chk("stall_fb_wr",   128'(bus.fb_key_wr), 128'd0);
    tick();
    @(negedge clk); #1;
    chk("stall_rd2",     128'(bus.in_key_rd), 128'd0);
    tick();
    bus.fb_key_full = 1'b0;
    @(negedge clk); #1;
    chk("release_rd",    128'(bus.in_key_rd), 128'd1);
    chk("release_fb_wr", 128'(bus.fb_key_wr), 128'd1);
    drain(20);

    // Round 10 accepted with the feedback FIFO full.
    do_reset();
    sw0 = store_writes; fw0 = fb_writes;
    for (int i = 0; i < 9; i++) src_q.push_back(rand_key());
    for (int i = 0; i < 9; i++) begin
      tick();
      @(negedge clk);
    end
    src_q.push_back(rand_key());
    tick();
    bus.fb_key_full = 1'b1;
    @(negedge clk); #1;
    chk("last_rd",     128'(bus.in_key_rd), 128'd1);
    tick();
    @(negedge clk); #1;
    chk("last_out_wr", 128'(bus.out_key_wr), 128'd1);
    chk("last_fb_wr",  128'(bus.fb_key_wr), 128'd0);
`ifdef EXPAND_KEY_ROUND_TAG_EN
    chk("last_round",  128'(bus.out_round), 128'd10);
`endif
    tick();
    bus.fb_key_full = 1'b0;
    @(negedge clk); #1;
    chk("last_fb_release", 128'(bus.fb_key_wr), 128'd1);
    src_q.push_back(rand_key());
    drain(20);
    chk("last_store_cnt", 128'(store_writes - sw0), 128'd11);
    chk("last_fb_cnt",    128'(fb_writes - fw0), 128'd10);

    // out_key_full toggling under continuous input.
    do_reset();
    sw0 = store_writes; fw0 = fb_writes;
    toggle_full = 1'b1;
    for (int i = 0; i < 20; i++) src_q.push_back(rand_key());
    drain(200);
    toggle_full = 1'b0;
    bus.out_key_full = 1'b0;
    chk("toggle_store_cnt", 128'(store_writes - sw0), 128'd20);
    chk("toggle_fb_cnt",    128'(fb_writes - fw0), 128'd18);

    // Asynchronous reset mid-cycle with both slots valid.
    do_reset();
    for (int i = 0; i < 3; i++) src_q.push_back(rand_key());
    tick();
    @(negedge clk);
    tick();
    #2;
    bus.in_key_empty = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("arst_rd",     128'(bus.in_key_rd), 128'd0);
    chk("arst_out_wr", 128'(bus.out_key_wr), 128'd0);
    chk("arst_fb_wr",  128'(bus.fb_key_wr), 128'd0);
    chk("arst_out_key", bus.out_key, 128'd0);
`ifdef EXPAND_KEY_ROUND_TAG_EN
    chk("arst_round",  128'(bus.out_round), 128'd1);
`endif
    src_q.delete();
    store_q.delete();
    fb_q.delete();
    model_round = 4'd1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    src_q.push_back(rand_key());
    tick();
    tick();
    @(negedge clk); #1;
    chk("post_rst_wr", 128'(bus.out_key_wr), 128'd1);
`ifdef EXPAND_KEY_ROUND_TAG_EN
    chk("post_rst_round", 128'(bus.out_round), 128'd1);
`endif
    drain(20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/expand_key3_128.md
# expand_key3_128

Final stage of the AES-128 key-expansion pipeline. It sits directly downstream of the word-2 stage and reads that stage's output FIFO. Each cycle it can complete word 3 of a round key (word3 ^= word2), tag the key with its round number and buffer it. Every round key goes to the round-key store FIFO; rounds 1–9 also go to the feedback FIFO that feeds the first expansion stage for the next round.

## Interface
- NUM_ROUNDS, 10: round keys produced per cipher key. Counter wraps after this many.
- clock  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low. Low clears all state immediately.
- in_key  in  128  partially expanded key from the word-2 stage FIFO. Byte i = bits [i*8 +: 8]; word w = bytes 4w..4w+3.
- in_key_rd  out  1  pop strobe for the input FIFO.
- in_key_empty  in  1  input FIFO empty.
- out_key  out  128  completed round key to the round-key store FIFO.
- out_key_wr  out  1  push strobe for the store FIFO.
- out_key_full  in  1  store FIFO full.
- fb_key  out  128  completed key to the stage-1 feedback FIFO.
- fb_key_wr  out  1  push strobe for the feedback FIFO.
- fb_key_full  in  1  feedback FIFO full.
- out_round  out  4  round index (1..NUM_ROUNDS) of the key on out_key. Present only with the configuration macro.

## Operation
- Datapath:
  - out bytes 0..11 = in bytes 0..11.
  - out byte 12+j = in byte 12+j ^ in byte 8+j, for j = 0..3.
  - Purely bytewise XOR, no carries.
- Two single-entry output slots, "store" and "fb". Each slot holds data plus a valid bit.
  - A slot is *free* this cycle when its valid bit is 0, or when it is valid and its FIFO is not full (it drains this cycle).
- Round counter `round`, 4 bits, range 1..NUM_ROUNDS. Reset value 1.
- State machine:
  - FILL: round < NUM_ROUNDS. Accept requires !in_key_empty, store free and fb free. On accept, load both slots, round++.
  - LAST: round == NUM_ROUNDS. Accept requires !in_key_empty and store free. On accept, load the store slot only, round := 1, state := FILL.
  - Enter LAST when FILL accepts with round == NUM_ROUNDS−1.
- in_key_rd = accept, combinational. It is never asserted while in_key_empty is high.
- out_key_wr = store.valid && !out_key_full. fb_key_wr = fb.valid && !fb_key_full. Both combinational from registered valid bits.
- Drain and reload of the same slot in one cycle: valid stays 1 and the data is replaced. No bubble.
- The store and fb slots drain independently. A stalled feedback FIFO blocks acceptance but never blocks the store slot from draining.
- Reset mid-operation:
  - Both valid bits clear, round := 1, state := FILL.
  - Any keys still in the slots are lost. Upstream is reset together with this block.

## Timing
- Reset values:
  - in_key_rd, out_key_wr, fb_key_wr = 0.
  - out_key, fb_key = 0.
  - out_round = 1.
- Latency: key accepted at edge T is presented with its write strobe in cycle T+1 when the FIFO is not full.
- Throughput: one key per cycle with no backpressure. Ten accepted keys produce ten store writes and nine feedback writes.
- Outputs are registered. The only combinational paths are the full/empty inputs to the rd/wr strobes.
- out_key and fb_key hold their last value while the slot is invalid.

## Configuration
- EXPAND_KEY_ROUND_TAG_EN defined:
  - A 4-bit round tag is stored in the store slot and driven on out_round.
  - The tag is the value of `round` at accept.
  - It holds between writes.
- Not defined:
  - out_round port and the tag register are absent.
  - Round counting and LAST behaviour are unchanged.

## Structure
- Shared package aes_key_pkg:
  - key_t (logic [127:0])
  - byte_t
  - round_t (logic [3:0])
  - NUM_ROUNDS constant
  - state enum {FILL, LAST}
- Sub-module key_out_slot, instantiated twice:
  - Parameterised data width.
  - Ports: load, data_in, full, valid, wr, data_out, free.
  - The store instance is widened by 4 bits when the tag is enabled.

## Test plan
- FIPS-197 round-1 fragment: in bytes 8..11 = 23,a3,39,39 and bytes 12..15 = 09,cf,4f,3c, FIFOs not full → next cycle out_key_wr = fb_key_wr = 1 and out bytes 12..15 = 2a,6c,76,05; out_round = 1.
- Ten back-to-back keys, no backpressure → ten out_key_wr pulses with rounds 1..10, nine fb_key_wr pulses. The 11th key is tagged round 1.
- fb_key_full held high in FILL with the fb slot valid → in_key_rd = 0 and the store slot still drains. Releasing full resumes acceptance the same cycle.
- round = 10 with fb_key_full = 1 → the key is still accepted, only out_key_wr pulses, round returns to 1.
- out_key_full toggling every cycle under continuous input → no key is lost or duplicated, and order is preserved.
- reset pulled low asynchronously mid-cycle with both slots valid → all strobes drop immediately and round = 1. The first key after release is tagged round 1.
